// File: rtl/irb_pkg.sv
// Shared types and sizes for the DW-kernel tile path.
// Weight width, tile size and the tile sequencer state.
package irb_pkg;

  localparam int WG_W       = 8;
  localparam int KDW_K      = 3;
  localparam int KDW_NCH    = 32;
  localparam int KDW_N_ELEM = KDW_K * KDW_K * KDW_NCH;
  localparam int KDW_AW     = $clog2(KDW_N_ELEM);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    READ,
    DRAIN
  } kdw_state_t;

endpackage

// File: rtl/kdw_tile_ctrl.sv
// KDW tile sequencer: loads a kernel tile into the KDW RAM from a
// valid/ready stream, then replays it npix times to the DW PE.
//   clk, rst_n            clock, async active-low reset
//   start_load, ld_*      tile load request and weight stream
//   load_done             pulse after the last weight is written
//   rd_start, rd_npix     replay request and pass count
//   rd_en                 PE enable (0 holds the current element)
//   kw_data/valid/last    weight stream to the PE
//   rd_done               pulse with the final element
//   ram_*                 KDW RAM port (1-cycle synchronous read)
module kdw_tile_ctrl
  import irb_pkg::*;
#(
  parameter int K      = 3,
  parameter int NCH    = 32,
  parameter int NPIX_W = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_load,
  input  logic                          ld_valid,
  input  logic [WG_W-1:0]               ld_data,
  output logic                          ld_ready,
  output logic                          load_done,
  input  logic                          rd_start,
  input  logic [NPIX_W-1:0]             rd_npix,
  input  logic                          rd_en,
  output logic [WG_W-1:0]               kw_data,
  output logic                          kw_valid,
  output logic                          kw_last,
  output logic                          rd_done,
  output logic [$clog2(K*K*NCH)-1:0]    ram_addr,
  output logic [WG_W-1:0]               ram_data,
  output logic                          ram_write,
  input  logic [WG_W-1:0]               ram_res
);

  localparam int N  = K * K * NCH;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  kdw_state_t        state;
  logic [AW-1:0]     wcnt;
  logic [AW-1:0]     rcnt;
  logic [NPIX_W-1:0] pcnt;
  logic [NPIX_W-1:0] npix;
  logic              ld_hs;

  assign ld_ready = (state == LOAD);
  assign ld_hs    = ld_ready && ld_valid;

  // RAM port is steered straight from the counters so the read
  // data lines up one cycle after the issue.
  assign ram_write = ld_hs;
  assign ram_data  = ld_hs ? ld_data : '0;
  assign kw_data   = ram_res;

  always_comb begin
    ram_addr = '0;
    unique case (1'b1)
      state == LOAD: ram_addr = wcnt;
      state == READ: ram_addr = rcnt;
      default:       ram_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      pcnt      <= '0;
      npix      <= '0;
      load_done <= 1'b0;
      kw_valid  <= 1'b0;
      kw_last   <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      kw_valid  <= 1'b0;
      kw_last   <= 1'b0;
      rd_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_load) begin
            wcnt  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            if (wcnt == LAST) begin
              wcnt      <= '0;
              load_done <= 1'b1;
              state     <= READY;
            end else begin
              wcnt <= wcnt + AW'(1);
            end
          end
        end
        READY: begin
          // rd_start has priority over a reload request
          if (rd_start) begin
            if (rd_npix == '0) begin
              rd_done <= 1'b1;
            end else begin
              npix  <= rd_npix;
              rcnt  <= '0;
              pcnt  <= '0;
              state <= READ;
            end
          end else if (start_load) begin
            wcnt  <= '0;
            state <= LOAD;
          end
        end
        READ: begin
          if (rd_en) begin
            kw_valid <= 1'b1;
            kw_last  <= (rcnt == LAST);
            if (rcnt == LAST) begin
              rcnt <= '0;
              if (pcnt == npix - NPIX_W'(1)) begin
                pcnt    <= '0;
                rd_done <= 1'b1;
                state   <= DRAIN;
              end else begin
                pcnt <= pcnt + NPIX_W'(1);
              end
            end else begin
              rcnt <= rcnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          state <= READY;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kdw_tile_ctrl.sv
// Bench for kdw_tile_ctrl with a behavioural KDW RAM beside it.
// Load/replay scenarios checked against a shadow tile model.
module tb_kdw_tile_ctrl;
  import irb_pkg::*;

  localparam int N      = KDW_N_ELEM;
  localparam int AW     = $clog2(N);
  localparam int NPIX_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_load;
  logic              ld_valid;
  logic [WG_W-1:0]   ld_data;
  logic              ld_ready;
  logic              load_done;
  logic              rd_start;
  logic [NPIX_W-1:0] rd_npix;
  logic              rd_en;
  logic [WG_W-1:0]   kw_data;
  logic              kw_valid;
  logic              kw_last;
  logic              rd_done;
  logic [AW-1:0]     ram_addr;
  logic [WG_W-1:0]   ram_data;
  logic              ram_write;
  logic [WG_W-1:0]   ram_res;

  logic [WG_W-1:0] mem [N];
  logic [WG_W-1:0] exp_tile [N];
  logic [WG_W-1:0] first_tile [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // KDW RAM: 1-cycle read, write-through
  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_addr] <= ram_data;
      ram_res       <= ram_data;
    end else begin
      ram_res <= mem[ram_addr];
    end
  end

  kdw_tile_ctrl #(.K(3), .NCH(32), .NPIX_W(NPIX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_done  (load_done),
    .rd_start   (rd_start),
    .rd_npix    (rd_npix),
    .rd_en      (rd_en),
    .kw_data    (kw_data),
    .kw_valid   (kw_valid),
    .kw_last    (kw_last),
    .rd_done    (rd_done),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_write  (ram_write),
    .ram_res    (ram_res)
  );

  task automatic test_reset();
    rst_n = 1'b0; start_load = 0; ld_valid = 0; ld_data = 0;
    rd_start = 0; rd_npix = 0; rd_en = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ld_ready, load_done, kw_valid, kw_last, rd_done, ram_write} !== 6'b0
        || ram_addr !== '0 || ram_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b done=%b v=%b l=%b rdn=%b wr=%b a=%0d d=%0d want all 0",
               ld_ready, load_done, kw_valid, kw_last, rd_done, ram_write, ram_addr, ram_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // vmode: 0 continuous valid, 1 alternate 1/0, 2 random
  task automatic do_load(input int vmode, input bit rnd_data, output int cycles);
    int idx = 0;
    int cyc = 0;
    bit v;
    @(negedge clk);
    start_load = 1; ld_valid = 0;
    @(negedge clk);
    start_load = 0;
    while (idx < N && cyc < 4 * N) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ld_valid = v;
      ld_data  = rnd_data ? WG_W'($urandom) : WG_W'(idx);
      #1;
      n_checks++;
      if (ld_ready !== 1'b1 || ram_write !== v || load_done !== 1'b0
          || (v && (ram_addr !== AW'(idx) || ram_data !== ld_data))) begin
        n_fail++;
        $display("FAIL load_beat idx=%0d got rdy=%b wr=%b a=%0d d=%0d done=%b want rdy=1 wr=%b a=%0d d=%0d done=0",
                 idx, ld_ready, ram_write, ram_addr, ram_data, load_done, v, idx, ld_data);
      end
      if (v) begin
        exp_tile[idx] = ld_data;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    ld_valid = 0;
    #1;
    n_checks++;
    if (idx != N || load_done !== 1'b1 || ld_ready !== 1'b0 || ram_write !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end got idx=%0d done=%b rdy=%b wr=%b want idx=%0d done=1 rdy=0 wr=0",
               idx, load_done, ld_ready, ram_write, N);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (load_done !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_pulse got done=%b rdy=%b want 0 0", load_done, ld_ready);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_tile[i]) begin
        n_fail++;
        $display("FAIL ram_contents addr=%0d got %0d want %0d", i, mem[i], exp_tile[i]);
      end
    end
    cycles = cyc;
  endtask

  // mode: 0 rd_en always 1, 1 low every 3rd cycle, 2 random
  task automatic do_read(input int npix, input int mode, input bit inj_sl,
                         input bit both, input int rst_at);
    int total = npix * N;
    int k = 0;
    int cyc = 0;
    bit ev = 0;
    bit e;
    @(negedge clk);
    rd_start = 1; rd_npix = NPIX_W'(npix); start_load = both; rd_en = 0;
    @(negedge clk);
    rd_start = 0; start_load = 0;
    if (npix == 0) begin
      #1;
      n_checks++;
      if (rd_done !== 1'b1 || kw_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL npix0_done got done=%b v=%b want 1 0", rd_done, kw_valid);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (rd_done !== 1'b0 || kw_valid !== 1'b0 || ld_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL npix0_after got done=%b v=%b rdy=%b want 0 0 0", rd_done, kw_valid, ld_ready);
      end
      return;
    end
    while (cyc < 4 * total + 10) begin
      #1;
      n_checks++;
      if (kw_valid !== ev || ram_write !== 1'b0 || ld_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_valid k=%0d got v=%b wr=%b rdy=%b want v=%b wr=0 rdy=0",
                 k, kw_valid, ram_write, ld_ready, ev);
      end
      if (ev) begin
        n_checks++;
        if (kw_data !== exp_tile[k % N] || kw_last !== (k % N == N - 1)) begin
          n_fail++;
          $display("FAIL rd_data k=%0d got d=%0d last=%b want d=%0d last=%b",
                   k, kw_data, kw_last, exp_tile[k % N], (k % N == N - 1));
        end
        k++;
      end
      n_checks++;
      if (rd_done !== (ev && k == total)) begin
        n_fail++;
        $display("FAIL rd_done k=%0d got %b want %b", k, rd_done, (ev && k == total));
      end
      if (k == total) break;
      if (rst_at >= 0 && k == rst_at) begin
        #1 rst_n = 0;
        #1;
        n_checks++;
        if ({ld_ready, load_done, kw_valid, kw_last, rd_done, ram_write} !== 6'b0
            || ram_addr !== '0) begin
          n_fail++;
          $display("FAIL async_reset got rdy=%b done=%b v=%b l=%b rdn=%b wr=%b a=%0d want all 0",
                   ld_ready, load_done, kw_valid, kw_last, rd_done, ram_write, ram_addr);
        end
        rd_en = 0;
        @(negedge clk);
        rst_n = 1;
        return;
      end
      e = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 != 2) : 1'($urandom_range(0, 1));
      rd_en = e;
      start_load = inj_sl && (cyc == 40);
      ev = e;
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (k != total) begin
      n_fail++;
      $display("FAIL rd_timeout got %0d elements want %0d", k, total);
    end
    rd_en = 0; start_load = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if (rd_done !== 1'b0 || kw_valid !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after got done=%b v=%b rdy=%b want 0 0 0", rd_done, kw_valid, ld_ready);
    end
  endtask

  task automatic test_load_continuous();
    int c;
    do_load(0, 0, c);
    n_checks++;
    if (c != N) begin
      n_fail++;
      $display("FAIL load_cycles got %0d want %0d", c, N);
    end
    for (int i = 0; i < N; i++) first_tile[i] = exp_tile[i];
  endtask

  task automatic test_load_toggle();
    int c;
    do_load(1, 0, c);
    n_checks++;
    if (c != 2 * N - 1) begin
      n_fail++;
      $display("FAIL toggle_cycles got %0d want %0d", c, 2 * N - 1);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== first_tile[i]) begin
        n_fail++;
        $display("FAIL toggle_same addr=%0d got %0d want %0d", i, mem[i], first_tile[i]);
      end
    end
  endtask

  task automatic test_read_two_pass();
    do_read(2, 0, 0, 0, -1);
  endtask

  task automatic test_read_stall();
    do_read(1, 1, 0, 0, -1);
  endtask

  task automatic test_read_zero();
    do_read(0, 0, 0, 0, -1);
    do_read(1, 2, 1, 0, -1);
  endtask

  task automatic test_same_cycle();
    do_read(1, 0, 0, 1, -1);
  endtask

  task automatic test_random();
    int c;
    do_load(2, 1, c);
    do_read(3, 2, 0, 0, -1);
  endtask

  task automatic test_reset_mid_read();
    int c;
    do_read(2, 0, 0, 0, 100);
    @(negedge clk);
    rd_start = 1; rd_npix = 1; rd_en = 1;
    @(negedge clk);
    rd_start = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (kw_valid !== 1'b0 || rd_done !== 1'b0 || ram_addr !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc=%0d got v=%b done=%b a=%0d want 0 0 0",
                 i, kw_valid, rd_done, ram_addr);
      end
      @(negedge clk);
    end
    rd_en = 0;
    do_load(2, 1, c);
    do_read(1, 0, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_load_continuous();
    test_load_toggle();
    test_read_two_pass();
    test_read_stall();
    test_read_zero();
    test_same_cycle();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
